aes128_comb: RTL and testbench
==============================

Name: aes128_comb

Overview:
- AES-128 encryption block (FIPS-197), single-cycle.
- A fully combinational 10-round cipher and key-expansion datapath feeds one output register.
- Used wherever a one-shot 128-bit block encryption is needed with a 1-cycle latency and no iteration control.
- Encrypt only; no decryption path.

Parameters:
- None. Key size is fixed at 128 bits; round count is fixed at 10.

Ports:
- clk  input  1  Rising-edge clock.
- rst_n  input  1  Asynchronous, active-low reset.
- in_valid  input  1  Qualifies plaintext/key for capture of the result on this edge.
- plaintext  input  128  Input block; bits [127:120] = byte 0 (state row 0, col 0). Bytes fill the state column-major.
- key  input  128  Cipher key; bits [127:120] = key byte 0, same byte order.
- ciphertext  output  128  Registered result, same byte order.
- out_valid  output  1  High for exactly one cycle when ciphertext holds a new result.

Behaviour:
- Reset: the block has one clock; reset is asynchronous and active-low.
  - While rst_n=0: ciphertext=128'h0 and out_valid=0, immediately and independent of clk.
  - Release is sampled by the next rising edge.
- Datapath (combinational from plaintext/key):
  - Key expansion: 44 words w[0..43], w[0..3] = key. For i%4==0: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ Rcon.
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 (placed in the MS byte).
  - Otherwise w[i] = w[i-4] ^ w[i-1].
  - Initial AddRoundKey with w[0..3].
  - Rounds 1–9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10: SubBytes, ShiftRows, AddRoundKey. No MixColumns in round 10.
- S-box: standard FIPS-197 forward S-box, implemented as a constant lookup.
- MixColumns: over GF(2^8) with reduction polynomial 0x11b.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
  - Matrix rows: [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
- ShiftRows: row r rotated left by r bytes; row 0 unchanged.
- Registering:
  - On a rising clk edge with rst_n=1 and in_valid=1: ciphertext <= combinational result, out_valid <= 1.
  - With in_valid=0: ciphertext holds its value, out_valid <= 0.
- Latency: exactly 1 cycle from the sampled in_valid edge.
  - Throughput: one block per cycle, so back-to-back in_valid is supported.
- Inputs may change every cycle. Only the values present at the capturing edge matter. There is no internal state other than the output register.
- Reset asserted mid-stream clears ciphertext and out_valid at once. A result in flight is discarded.
- No X propagation from the datapath: every S-box index is defined for all 256 values.

Test Plan:
- Reset: hold rst_n=0, toggle inputs -> ciphertext=0, out_valid=0. Assert rst_n asynchronously between edges -> outputs clear immediately.
- FIPS-197 App. B vector: plaintext=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, in_valid=1 for one edge -> next cycle ciphertext=3925841d02dc09fbdc118597196a0b32, out_valid=1 for one cycle. Afterwards ciphertext is held and out_valid=0.
- FIPS-197 App. C.1 vector: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero plaintext and key -> ciphertext=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Back-to-back: App. B then App. C.1 on consecutive edges with in_valid held high -> two consecutive out_valid cycles with the correct results in order.
- Hold: change plaintext/key with in_valid=0 -> ciphertext unchanged, out_valid=0. Reset mid-stream -> out_valid=0 and ciphertext=0 on the following cycles.

Source files
------------

// File: rtl/aes128_comb.sv
// AES-128 encryption (FIPS-197) with one-cycle latency. The key expansion and
// all ten rounds are unrolled into a single combinational path. Only the
// result is registered.
module aes128_comb (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         out_valid
);

    // NOTE: the S-box is a constant ROM. It holds no state, so reset does not touch it.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // State byte n (n = 4*col + row) sits at bits [127-8n -: 8].
    function automatic logic [7:0] get_byte(input logic [127:0] s, input int n);
        return s[8*(15-n) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Row r of the output takes column (c + r) mod 4 of the input.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[8*(15-(4*c+rw)) +: 8] = get_byte(s, 4*((c+rw)%4) + rw);
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c+1);
            a2 = get_byte(s, 4*c+2);
            a3 = get_byte(s, 4*c+3);
            r[8*(15-4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[8*(14-4*c)   +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[8*(13-4*c)   +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[8*(12-4*c)   +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input int rnd);
        case (rnd)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Rolling key expansion: produces w[4i..4i+3] from w[4i-4..4i-1].
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [127:0] state;
    logic [127:0] round_key;
    logic [127:0] result;
    logic [127:0] ciphertext_d, ciphertext_q;
    logic         out_valid_d, out_valid_q;

    // Unrolled cipher: initial AddRoundKey, nine full rounds, final round without MixColumns.
    always_comb begin
        state     = plaintext ^ key;
        round_key = key;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            round_key = next_key(round_key, rcon(rnd));
            state     = shift_rows(sub_bytes(state));
            if (rnd != 10) state = mix_columns(state);
            state     = state ^ round_key;
        end
        result = state;
    end

    // Capture the result when in_valid is high; otherwise hold it and drop out_valid.
    always_comb begin
        // NOTE: defaults come first so that every path assigns every output and no latch is inferred.
        ciphertext_d = ciphertext_q;
        out_valid_d  = 1'b0;
        if (in_valid) begin
            ciphertext_d = result;
            out_valid_d  = 1'b1;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (!rst_n) begin
            ciphertext_q <= 128'h0;
            out_valid_q  <= 1'b0;
        end else begin
            ciphertext_q <= ciphertext_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign ciphertext = ciphertext_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_aes128_comb.sv
// Self-checking bench for aes128_comb. Expected results come from published
// FIPS-197 vectors and from a byte-array AES model whose S-box is derived
// algebraically (GF(2^8) inverse followed by the affine transform).
module tb_aes128_comb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic [127:0] ciphertext;
    logic         out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_sbox [256];

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_comb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .plaintext  (plaintext),
        .key        (key),
        .ciphertext (ciphertext),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic init_model();
        logic [7:0] x, inv;
        for (int i = 0; i < 256; i++) begin
            x   = 8'(i);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);   // x^254 = x^-1, and 0 maps to 0
            m_sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   w [44][4];
        logic [7:0]   t [4];
        logic [7:0]   rc;
        logic [127:0] sh, out;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            sh = pt << (8*i); st[i] = sh[127:120];
            sh = k  << (8*i); w[i/4][i%4] = sh[127:120];
        end
        for (int i = 4; i < 44; i++) begin
            for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
            if (i % 4 == 0) begin
                t[0] = m_sbox[w[i-1][1]] ^ rc;
                t[1] = m_sbox[w[i-1][2]];
                t[2] = m_sbox[w[i-1][3]];
                t[3] = m_sbox[w[i-1][0]];
                rc   = gmul(rc, 8'h02);
            end
            for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
        end
        for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[i/4][i%4];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) st[i] = m_sbox[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[4*c+r] = st[4*((c+r)%4)+r];
            st = tmp;
            if (rd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        tmp[4*c+r] = gmul(st[4*c+r], 8'h02) ^ gmul(st[4*c+(r+1)%4], 8'h03)
                                   ^ st[4*c+(r+2)%4] ^ st[4*c+(r+3)%4];
                st = tmp;
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rd + i/4][i%4];
        end
        out = '0;
        for (int i = 0; i < 16; i++) out = {out[119:0], st[i]};
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            plaintext = rand128();
            key       = rand128();
            tick();
            n_checks++;
            if (ciphertext !== 128'h0) begin
                n_fail++; $display("FAIL reset_ct: got %h want 0", ciphertext);
            end
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_ov: got %b want 0", out_valid);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || ciphertext !== 128'h0) begin
            n_fail++; $display("FAIL reset_release: ov %b ct %h want 0/0", out_valid, ciphertext);
        end
    endtask

    task automatic test_vectors();
        logic [127:0] pts [3];
        logic [127:0] keys [3];
        logic [127:0] cts [3];
        pts  = '{PT_B, PT_C, 128'h0};
        keys = '{KEY_B, KEY_C, 128'h0};
        cts  = '{CT_B, CT_C, CT_Z};
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1; plaintext = pts[v]; key = keys[v];
            tick();
            n_checks++;
            if (ciphertext !== cts[v] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL vector%0d: ct %h ov %b want %h 1", v, ciphertext, out_valid, cts[v]);
            end
            in_valid = 1'b0; plaintext = rand128(); key = rand128();
            tick();
            n_checks++;
            if (ciphertext !== cts[v] || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL vector%0d_hold: ct %h ov %b want %h 0", v, ciphertext, out_valid, cts[v]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] exp_ct;
        logic         exp_ov;
        exp_ct = ciphertext === CT_Z ? CT_Z : 128'hx;
        exp_ct = CT_Z;    // last captured value from test_vectors
        for (int i = 0; i < 60; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            plaintext = rand128();
            key       = rand128();
            if (in_valid) exp_ct = aes_model(plaintext, key);
            exp_ov = in_valid;
            tick();
            n_checks++;
            if (ciphertext !== exp_ct || out_valid !== exp_ov) begin
                n_fail++; $display("FAIL random%0d: ct %h ov %b want %h %b", i, ciphertext, out_valid, exp_ct, exp_ov);
            end
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; plaintext = PT_B; key = KEY_B;
        tick();
        n_checks++;
        if (ciphertext !== CT_B || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: ct %h ov %b want %h 1", ciphertext, out_valid, CT_B);
        end
        plaintext = PT_C; key = KEY_C;
        tick();
        n_checks++;
        if (ciphertext !== CT_C || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: ct %h ov %b want %h 1", ciphertext, out_valid, CT_C);
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (ciphertext !== CT_C || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_after: ct %h ov %b want %h 0", ciphertext, out_valid, CT_C);
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            plaintext = rand128(); key = rand128();
            tick();
            n_checks++;
            if (ciphertext !== CT_C || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL hold%0d: ct %h ov %b want %h 0", i, ciphertext, out_valid, CT_C);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; plaintext = PT_B; key = KEY_B;
        tick();
        n_checks++;
        if (ciphertext !== CT_B || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_capture: ct %h ov %b want %h 1", ciphertext, out_valid, CT_B);
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ciphertext !== 128'h0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_clear: ct %h ov %b want 0 0", ciphertext, out_valid);
        end
        plaintext = PT_C; key = KEY_C;
        tick();
        n_checks++;
        if (ciphertext !== 128'h0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_held_in_reset: ct %h ov %b want 0 0", ciphertext, out_valid);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        n_checks++;
        if (ciphertext !== 128'h0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_after_release: ct %h ov %b want 0 0", ciphertext, out_valid);
        end
        in_valid = 1'b1; plaintext = PT_C; key = KEY_C;
        tick();
        n_checks++;
        if (ciphertext !== CT_C || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_recover: ct %h ov %b want %h 1", ciphertext, out_valid, CT_C);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        init_model();
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1, "timeout");
    end

endmodule
